// File: rtl/regbank_pkg.sv
// Shared constants and enums for the register-bank arbiter and its dump sequencer.
package regbank_pkg;

  localparam int NREGS_DEF = 8;
  localparam int DW_DEF    = 16;
  localparam int AW_DEF    = 3;

  typedef enum logic [1:0] {ARB, DUMP, FLUSH} state_e;
  typedef enum logic {REQ_CPU, REQ_DBG} req_e;

endpackage

// File: rtl/regbank_dump_seq.sv
// Dump sequencer: walks r0..r(NREGS-1) on the bank read port and streams the contents out.
module regbank_dump_seq
  import regbank_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dump_start,
  input  logic [DW-1:0] rb_rdata,
  output logic          arb_idle,
  output logic          seq_rd,
  output logic [AW-1:0] seq_addr,
  output logic          dump_busy,
  output logic          dump_valid,
  output logic [AW-1:0] dump_idx,
  output logic [DW-1:0] dump_data
);

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ARB;
      cnt_q      <= '0;
      dump_valid <= 1'b0;
      dump_idx   <= '0;
      dump_data  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dump_valid <= (state_q == DUMP);
      if (state_q == DUMP) begin
        dump_idx  <= cnt_q;
        dump_data <= rb_rdata;
      end
    end
  end

  // The last entry is read in DUMP and surfaces during FLUSH.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB:   if (dump_start) state_d = DUMP;
      DUMP: begin
        if (cnt_q == LAST) state_d = FLUSH;
        else               cnt_d   = cnt_q + 1'b1;
      end
      FLUSH: begin
        cnt_d   = '0;
        state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  assign arb_idle  = (state_q == ARB);
  assign seq_rd    = (state_q == DUMP);
  assign seq_addr  = cnt_q;
  assign dump_busy = (state_q == DUMP) || (state_q == FLUSH);

endmodule

// File: rtl/regbank_arbiter.sv
// Arbitrates the single-port register bank between CPU and debug port, plus a bank dump.
// Build option REGBANK_CPU_PRIORITY_EN: CPU wins every tie instead of round-robin.
module regbank_arbiter
  import regbank_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  input  logic          dump_start,
  output logic          dump_busy,
  output logic          dump_valid,
  output logic [AW-1:0] dump_idx,
  output logic [DW-1:0] dump_data,
  output logic          rb_we,
  output logic [AW-1:0] rb_addr,
  output logic [DW-1:0] rb_wdata,
  input  logic [DW-1:0] rb_rdata
);

  logic          arb_idle;
  logic          seq_rd;
  logic [AW-1:0] seq_addr;
  logic          arb_en;

  regbank_dump_seq #(
    .NREGS(NREGS),
    .DW   (DW),
    .AW   (AW)
  ) u_dump_seq (
    .clk       (clk),
    .rst       (rst),
    .dump_start(dump_start),
    .rb_rdata  (rb_rdata),
    .arb_idle  (arb_idle),
    .seq_rd    (seq_rd),
    .seq_addr  (seq_addr),
    .dump_busy (dump_busy),
    .dump_valid(dump_valid),
    .dump_idx  (dump_idx),
    .dump_data (dump_data)
  );

  // Grants are suppressed while reset is asserted so no access slips into a reset cycle.
  assign arb_en = rst & arb_idle;

`ifdef REGBANK_CPU_PRIORITY_EN
  assign cpu_gnt = arb_en & cpu_req;
  assign dbg_gnt = arb_en & dbg_req & ~cpu_req;
`else
  req_e last_winner;
  logic cpu_wins;

  assign cpu_wins = cpu_req & (~dbg_req | (last_winner == REQ_DBG));
  assign cpu_gnt  = arb_en & cpu_wins;
  assign dbg_gnt  = arb_en & dbg_req & ~cpu_wins;

  always_ff @(posedge clk) begin
    if (!rst)         last_winner <= REQ_DBG;
    else if (cpu_gnt) last_winner <= REQ_CPU;
    else if (dbg_gnt) last_winner <= REQ_DBG;
  end
`endif

  always_comb begin
    rb_we    = 1'b0;
    rb_addr  = '0;
    rb_wdata = '0;
    if (cpu_gnt) begin
      rb_we    = cpu_we;
      rb_addr  = cpu_addr;
      rb_wdata = cpu_wdata;
    end else if (dbg_gnt) begin
      rb_we    = dbg_we;
      rb_addr  = dbg_addr;
      rb_wdata = dbg_wdata;
    end else if (rst && seq_rd) begin
      rb_addr = seq_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
    end else begin
      cpu_rvalid <= cpu_gnt & ~cpu_we;
      dbg_rvalid <= dbg_gnt & ~dbg_we;
      if (cpu_gnt && !cpu_we) cpu_rdata <= rb_rdata;
      if (dbg_gnt && !dbg_we) dbg_rdata <= rb_rdata;
    end
  end

endmodule

// File: doc/regbank_arbiter.md
Name: regbank_arbiter

Overview:
- Shares the CPU's single-port 8x16 register bank between two requesters: the CPU core datapath and a debug/scan port.
- Contains a dump sequencer that reads r0..r7 back-to-back and streams them out for the bench or the debug host.
- The sequencer replaces ad-hoc hierarchical peeking at the register matrix.
- Sits between the CPU control FSM and the register bank.

Parameters:
- NREGS, 8, number of registers in the bank.
- DW, 16, register data width.
- AW, 3, register address width; must equal clog2(NREGS).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-low reset.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  register index.
- cpu_wdata  in  DW  write data.
- cpu_gnt  out  1  access performed this cycle.
- cpu_rvalid  out  1  cpu_rdata valid; one cycle after a read grant.
- cpu_rdata  out  DW  read data.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: same as the cpu_* ports, for the debug port.
- dump_start  in  1  one-cycle pulse; requests a full-bank dump.
- dump_busy  out  1  dump in progress.
- dump_valid  out  1  dump_idx/dump_data valid.
- dump_idx  out  AW  index of the dumped register.
- dump_data  out  DW  contents of the dumped register.
- rb_we  out  1  register bank write enable.
- rb_addr  out  AW  register bank address.
- rb_wdata  out  DW  register bank write data.
- rb_rdata  in  DW  register bank combinational read data for rb_addr.

Behaviour:
- Reset (rst=0 at posedge):
  - All outputs clear to 0.
  - State = ARB.
  - last_winner = DBG, so the CPU wins the first tie.
  - Dump counter = 0.
  - Reset mid-dump aborts the dump; no further dump_valid pulses.
- One bank access per cycle. gnt is combinational from the req inputs and the current state.
- rb_* outputs drive the granted requester's we/addr/wdata. When no grant is given, rb_we=0 and rb_addr=0.
- Read data:
  - On a read grant, rb_rdata is registered into the winner's *_rdata.
  - *_rvalid pulses one cycle later.
  - Write grants produce no rvalid.
- Handshake:
  - A requester holds req and its fields stable until it sees gnt=1 for one cycle.
  - Deasserting req before the grant is legal and drops the request.
- Arbitration in state ARB:
  - Only one req high: that requester is granted.
  - Both high: grant the requester that is not last_winner (round-robin).
  - last_winner updates on every grant.
- FSM states: ARB, DUMP, FLUSH.
  - ARB -> DUMP when dump_start=1. A grant issued in that same cycle still completes.
  - DUMP:
    - cpu_gnt = dbg_gnt = 0.
    - rb_we=0, rb_addr=cnt.
    - rb_rdata is registered to dump_data with dump_idx=cnt and dump_valid=1 on the next cycle.
    - cnt increments each cycle. At cnt=NREGS-1 -> FLUSH.
  - FLUSH: emits the final dump_valid (idx NREGS-1), then cnt=0 and -> ARB.
  - dump_busy=1 in DUMP and FLUSH.
  - dump_start is ignored outside ARB.
- Dump latency:
  - First dump_valid occurs 2 cycles after the dump_start edge.
  - Exactly NREGS consecutive dump_valid pulses, idx 0..NREGS-1 in order, no gaps.
- Pending requests during a dump stall; they are serviced in ARB under the normal round-robin rule.
- A write and a read to the same register are never simultaneous (single port), so no forwarding is needed.

Optional Feature:
- Macro REGBANK_CPU_PRIORITY_EN.
- Defined: fixed priority. CPU always wins ties; last_winner is unused.
- Undefined: round-robin as specified above.
- Dump behaviour is identical in both builds.

Decomposition:
- Shared package regbank_pkg:
  - Constants NREGS_DEF=8, DW_DEF=16, AW_DEF=3.
  - State enum {ARB, DUMP, FLUSH}.
  - Requester enum {REQ_CPU, REQ_DBG}.
- One natural sub-module: regbank_dump_seq, containing the counter, the DUMP/FLUSH states and the dump output registers.
- Arbitration and muxing stay in the top level.

Test Plan:
- Reset: hold rst=0 for 2 cycles with both reqs high -> all gnt/valid outputs 0. First cycle after release with both reqs high -> cpu_gnt=1.
- Round-robin: hold cpu_req and dbg_req high for 4 cycles -> grants alternate CPU, DBG, CPU, DBG. With REGBANK_CPU_PRIORITY_EN -> CPU all 4 cycles.
- CPU write then read: write r3=16'h1234, then read r3 -> cpu_rvalid one cycle after the read grant, cpu_rdata=16'h1234.
- Dump: preload rk=k*10 (k=0..7), pulse dump_start:
  - 8 consecutive dump_valid pulses, idx 0..7, data 0,10,...,70, first pulse 2 cycles after the start edge.
  - dump_busy high for 9 cycles.
- Stall during dump: assert dbg_req at the dump's second cycle -> no dbg_gnt until the first ARB cycle; granted then with correct data.
- Reset mid-dump: drive rst=0 after 3 dump_valid pulses -> dump_busy=0 and no further dump_valid. A new dump_start afterwards runs a complete 8-entry dump.
